sort_loader: RTL and testbench

- Upstream stage of the 4-lane nibble sorter.
- Accepts 4-bit values one per beat over a valid/ready handshake and packs them into one 16-bit word, first value in the most-significant lane.
- Presents the packed word with its own valid/ready handshake.
- A short batch closed with in_last is padded, so the sorter always gets a full word.
- Two word slots (collect and output), so the next batch can be collected while a finished word waits downstream.

---
 rtl/sort_pkg.sv | 11 +
 rtl/sort_loader.sv | 115 +++++++++++
 tb/tb_sort_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Lane and word constants and types shared by the nibble sorter and its loader.
package sort_pkg;

  localparam int unsigned W     = 4;
  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef logic [W-1:0]   lane_t;
  typedef logic [N*W-1:0] word_t;

endpackage

// File: rtl/sort_loader.sv
// Packs W-bit beats into an N-lane word (first beat in the top lane), padding
// short batches; collect and output slots let a new batch fill while one waits.
module sort_loader #(
  parameter int unsigned W   = sort_pkg::W,
  parameter int unsigned N   = sort_pkg::N,
  parameter logic [W-1:0] PAD = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*W-1:0]           out_data,
  output logic [$clog2(N+1)-1:0]   out_count
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(N + 1);

  logic [IDX_W-1:0] idx, idx_d;
  logic [N*W-1:0]   coll_word, coll_word_d;
  logic [CNT_W-1:0] coll_count, coll_count_d;
  logic             coll_full, coll_full_d;
  logic             in_ready_d;
  logic             out_valid_d;
  logic [N*W-1:0]   out_data_d;
  logic [CNT_W-1:0] out_count_d;

  logic             accept;
  logic             out_free;
  logic             complete;
  logic [N*W-1:0]   merged;

  // Lane insert, PAD fill on completion, and slot movement.
  always_comb begin
    accept   = in_valid & in_ready;
    out_free = !out_valid | out_ready;
    complete = accept & ((idx == IDX_W'(N - 1)) | in_last);

    merged = coll_word;
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (IDX_W'(i) == idx) begin
          merged[(N-1-i)*W +: W] = in_data;
        end else if (complete && (IDX_W'(i) > idx)) begin
          merged[(N-1-i)*W +: W] = PAD;
        end
      end
    end

    idx_d        = idx;
    coll_word_d  = coll_word;
    coll_count_d = coll_count;
    coll_full_d  = coll_full;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_count_d  = out_count;

    // A transfer empties the output slot unless a word is loaded below.
    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (coll_full) begin
      if (out_free) begin
        out_data_d  = coll_word;
        out_count_d = coll_count;
        out_valid_d = 1'b1;
        coll_full_d = 1'b0;
      end
    end else if (complete) begin
      idx_d = '0;
      if (out_free) begin
        out_data_d  = merged;
        out_count_d = CNT_W'(idx) + CNT_W'(1);
        out_valid_d = 1'b1;
      end else begin
        coll_word_d  = merged;
        coll_count_d = CNT_W'(idx) + CNT_W'(1);
        coll_full_d  = 1'b1;
      end
    end else if (accept) begin
      coll_word_d = merged;
      idx_d       = idx + IDX_W'(1);
    end

    in_ready_d = !coll_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      coll_word  <= '0;
      coll_count <= '0;
      coll_full  <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
    end else begin
      idx        <= idx_d;
      coll_word  <= coll_word_d;
      coll_count <= coll_count_d;
      coll_full  <= coll_full_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_count  <= out_count_d;
    end
  end

endmodule

// File: tb/tb_sort_loader.sv
// Directed, table-driven bench for sort_loader; a second instance with PAD=F
// runs the same stimulus to check pad fill.
module tb_sort_loader;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready;
  logic [3:0]  in_data;
  logic        in_ready, out_valid, p_in_ready, p_out_valid;
  logic [15:0] out_data, p_out_data;
  logic [2:0]  out_count, p_out_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sort_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  sort_loader #(.PAD(4'hF)) dut_pad (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(p_out_valid),
    .out_ready(out_ready), .out_data(p_out_data), .out_count(p_out_count)
  );

  typedef struct {
    logic        r, v, l, ordy;
    logic [3:0]  d;
    logic        chkd;
    logic        ev, eir;
    logic [15:0] ed, epd;
    logic [2:0]  ec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic v, input logic [3:0] d,
                              input logic l, input logic ordy, input logic chkd,
                              input logic ev, input logic [15:0] ed,
                              input logic [15:0] epd, input logic [2:0] ec,
                              input logic eir);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.l = l; x.ordy = ordy; x.chkd = chkd;
    x.ev = ev; x.ed = ed; x.epd = epd; x.ec = ec; x.eir = eir;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return at the next falling edge.
  task automatic step(input logic r, input logic v, input logic [3:0] d,
                      input logic l, input logic ordy);
    rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    // reset
    add(1, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 1);
    // 3,9,1,7 full batch
    add(0, 1, 4'h3, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4'h9, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4'h1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4'h7, 0, 1, 1, 1, 16'h3917, 16'h3917, 4, 1);
    add(0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
    // short batch 5,2
    add(0, 1, 4'h5, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4'h2, 1, 1, 1, 1, 16'h5200, 16'h52FF, 2, 1);
    add(0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
    // back-to-back stream 0..F
    for (int k = 0; k < 16; k++) begin
      logic [15:0] w;
      w = {4'(k - 3), 4'(k - 2), 4'(k - 1), 4'(k)};
      if (k % 4 == 3) add(0, 1, 4'(k), 0, 1, 1, 1, w, w, 4, 1);
      else            add(0, 1, 4'(k), 0, 1, 0, 0, 0, 0, 0, 1);
    end
    add(0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
    // partial A,B discarded by reset
    add(0, 1, 4'hA, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4'hB, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 4'h0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 1);
    add(0, 1, 4'h1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4'h2, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4'h3, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 4'h4, 0, 1, 1, 1, 16'h1234, 16'h1234, 4, 1);
    add(0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
    // single beat with in_last
    add(0, 1, 4'h6, 1, 1, 1, 1, 16'h6000, 16'h6FFF, 1, 1);
    add(0, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
      chk($sformatf("v%0d out_valid", i), 16'(out_valid), 16'(tbl[i].ev));
      chk($sformatf("v%0d in_ready", i), 16'(in_ready), 16'(tbl[i].eir));
      if (tbl[i].chkd) begin
        chk($sformatf("v%0d out_data", i), out_data, tbl[i].ed);
        chk($sformatf("v%0d out_count", i), 16'(out_count), 16'(tbl[i].ec));
        chk($sformatf("v%0d pad out_data", i), p_out_data, tbl[i].epd);
      end
    end

    // Backpressure: first word held, second word parks in the collect slot.
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 4'(k), 0, 0);
      chk($sformatf("bp beat%0d out_valid", k), 16'(out_valid), 16'(k >= 4));
      chk($sformatf("bp beat%0d in_ready", k), 16'(in_ready), 16'(k != 8));
      if (k >= 4) chk($sformatf("bp beat%0d out_data", k), out_data, 16'h1234);
    end
    step(0, 1, 4'h9, 0, 0);
    chk("bp hold out_data", out_data, 16'h1234);
    chk("bp hold in_ready", 16'(in_ready), 16'h0);
    step(0, 0, 4'h0, 0, 1);
    chk("bp drain out_valid", 16'(out_valid), 16'h1);
    chk("bp drain out_data", out_data, 16'h5678);
    chk("bp drain out_count", 16'(out_count), 16'h4);
    chk("bp drain in_ready", 16'(in_ready), 16'h1);
    step(0, 0, 4'h0, 0, 1);
    chk("bp idle out_valid", 16'(out_valid), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
